int_ctrl: RTL

Interrupt controller for the multicycle MIPS machine. It collects interrupt requests from the peripherals (timer, input device change, and others), latches them into pending bits, applies masking and fixed priority, and presents one request at a time to the CPU's CP0. The CPU enters the handler at 0x0180. The block sits between the device bridge and the CPU. Software configures it through word-addressed registers on the bridge.

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 21 ++
 rtl/int_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller:
// register map, FSM states and CTRL field positions.
package int_ctrl_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_MODE = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_t;

  localparam int CTRL_GEN     = 0;
  localparam int CTRL_INSVC   = 1;
  localparam int CTRL_ISR_LSB = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Source 0 has the highest priority.
module irq_prio_enc #(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic [NSRC-1:0] vec,
  output logic [IDW-1:0]  id,
  output logic            valid
);

  always_comb begin
    id    = '0;
    valid = |vec;
    // Scan downwards so the lowest set index is the last write.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) id = IDW'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending latch, masking, fixed
// priority and a one-at-a-time request handshake to CP0.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            int_req,
  output logic [IDW-1:0]  int_id,
  input  logic            int_ack,
  input  logic            eret
);

  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] prev;
  logic            gen;
  logic [IDW-1:0]  isr_id;
  state_t          state;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pend_nx;
  logic [NSRC-1:0] elig;
  logic [IDW-1:0]  win_id;
  logic            win_vld;
  logic            ack_ok;
  logic [31:0]     ctrl_rd;
  logic [31:0]     rd_nx;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:NSRC];

  assign ack_ok = (state == S_REQ) && int_ack;
  assign elig   = pend & mask & {NSRC{gen}};

  irq_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_enc (
    .vec   (elig),
    .id    (win_id),
    .valid (win_vld)
  );

  always_comb begin
    rise = irq_src & ~prev;
    clr  = '0;
    if (we && addr == REG_PEND) clr = wdata[NSRC-1:0];
    if (ack_ok) clr[int_id] = 1'b1;
    // Level bits just follow the input; only edge bits can clear.
    clr     = clr & mode;
    pend_nx = (mode & ((pend & ~clr) | rise))
            | (~mode & irq_src);
  end

  always_comb begin
    ctrl_rd                         = '0;
    ctrl_rd[CTRL_GEN]               = gen;
    ctrl_rd[CTRL_INSVC]             = (state == S_SERVICE);
    ctrl_rd[CTRL_ISR_LSB +: IDW]    = isr_id;
    rd_nx                           = '0;
    unique case (addr)
      REG_MASK: rd_nx[NSRC-1:0] = mask;
      REG_MODE: rd_nx[NSRC-1:0] = mode;
      REG_PEND: rd_nx[NSRC-1:0] = pend;
      REG_CTRL: rd_nx           = ctrl_rd;
      default:  rd_nx           = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask  <= '0;
      mode  <= '0;
      gen   <= 1'b0;
      pend  <= '0;
      prev  <= '0;
      rdata <= '0;
    end else begin
      prev  <= irq_src;
      pend  <= pend_nx;
      rdata <= rd_nx;
      if (we) begin
        unique case (1'b1)
          addr == REG_MASK: mask <= wdata[NSRC-1:0];
          addr == REG_MODE: mode <= wdata[NSRC-1:0];
          addr == REG_CTRL: gen  <= wdata[CTRL_GEN];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      int_req <= 1'b0;
      int_id  <= '0;
      isr_id  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            state   <= S_REQ;
            int_req <= 1'b1;
            int_id  <= win_id;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            state   <= S_SERVICE;
            int_req <= 1'b0;
            isr_id  <= int_id;
          end else if (!win_vld) begin
            state   <= S_IDLE;
            int_req <= 1'b0;
          end else begin
            int_id  <= win_id;
          end
        end
        S_SERVICE: begin
          if (eret) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
